// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned MAX_MASTERS       = 8;
    localparam int unsigned IDX_W             = 3;
    localparam int unsigned DEF_NR_MASTERS    = 4;
    localparam int unsigned DEF_BEGIN_TIMEOUT = 16;
    localparam int unsigned DEF_BUS_TIMEOUT   = 256;
    localparam int unsigned MIN_CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_WAIT_BEGIN = 3'd2,
        ST_BUSY       = 3'd3,
        ST_ABORT      = 3'd4
    } arb_state_e;

    // Index to one-hot over the largest supported master count.
    function automatic logic [MAX_MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_MASTERS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Counter width able to hold limit-1, never below MIN_CNT_W bits.
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit);
        if (w < MIN_CNT_W) begin
            w = MIN_CNT_W;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_select.sv
// Combinational round-robin winner search starting just above last_winner.
module rr_priority_select
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NR_MASTERS = DEF_NR_MASTERS
) (
    input  logic [NR_MASTERS-1:0] request_i,
    input  logic [IDX_W-1:0]      last_winner_i,
    output logic [IDX_W-1:0]      winner_o,
    output logic                  valid_o
);

    // Indices above last_winner take precedence, then wrap to the low indices.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int j = 0; j < int'(NR_MASTERS); j++) begin
            if (!valid_o && request_i[j] && (IDX_W'(j) > last_winner_i)) begin
                valid_o  = 1'b1;
                winner_o = IDX_W'(j);
            end
        end
        for (int j = 0; j < int'(NR_MASTERS); j++) begin
            if (!valid_o && request_i[j] && (IDX_W'(j) <= last_winner_i)) begin
                valid_o  = 1'b1;
                winner_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with begin-timeout and bus watchdog abort.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NR_MASTERS    = DEF_NR_MASTERS,
    parameter int unsigned BEGIN_TIMEOUT = DEF_BEGIN_TIMEOUT,
    parameter int unsigned BUS_TIMEOUT   = DEF_BUS_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NR_MASTERS-1:0] request,
    output logic [NR_MASTERS-1:0] grant,
    input  logic                  begin_transaction_in,
    input  logic                  end_transaction_in,
    output logic                  end_transaction_out,
    output logic                  error_out,
    output logic                  bus_busy,
    output logic [IDX_W-1:0]      active_master
);

    localparam int unsigned WAIT_W = cnt_width(BEGIN_TIMEOUT);
    localparam int unsigned BUS_W  = cnt_width(BUS_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BEGIN_TIMEOUT - 1);
    localparam logic [BUS_W-1:0]  BUS_LAST  = BUS_W'(BUS_TIMEOUT - 1);

    arb_state_e            state_q;
    logic [NR_MASTERS-1:0] grant_q;
    logic                  end_out_q;
    logic                  error_q;
    logic                  busy_q;
    logic [IDX_W-1:0]      active_q;
    logic [IDX_W-1:0]      last_winner_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic [BUS_W-1:0]      bus_cnt_q;

    logic [IDX_W-1:0]      sel_winner;
    logic                  sel_valid;

    rr_priority_select #(
        .NR_MASTERS (NR_MASTERS)
    ) u_select (
        .request_i     (request),
        .last_winner_i (last_winner_q),
        .winner_o      (sel_winner),
        .valid_o       (sel_valid)
    );

    // State, counters and registered outputs; pulses default low every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            end_out_q     <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            active_q      <= '0;
            last_winner_q <= IDX_W'(NR_MASTERS - 1);
            wait_cnt_q    <= '0;
            bus_cnt_q     <= '0;
        end else begin
            grant_q   <= '0;
            end_out_q <= 1'b0;
            error_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    bus_cnt_q  <= '0;
                    if (sel_valid) begin
                        state_q       <= ST_GRANT;
                        grant_q       <= NR_MASTERS'(idx_to_onehot(sel_winner));
                        last_winner_q <= sel_winner;
                        active_q      <= sel_winner;
                        busy_q        <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    state_q    <= ST_WAIT_BEGIN;
                    wait_cnt_q <= '0;
                end
                ST_WAIT_BEGIN: begin
                    if (begin_transaction_in) begin
                        wait_cnt_q <= '0;
                        bus_cnt_q  <= '0;
                        if (end_transaction_in) begin
                            // Zero-length transfer: bus is free again at once.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (end_transaction_in) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        bus_cnt_q <= '0;
                    end else if (bus_cnt_q == BUS_LAST) begin
                        state_q   <= ST_ABORT;
                        end_out_q <= 1'b1;
                        error_q   <= 1'b1;
                        bus_cnt_q <= '0;
                    end else begin
                        bus_cnt_q <= bus_cnt_q + 1'b1;
                    end
                end
                ST_ABORT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    wait_cnt_q <= '0;
                    bus_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign grant               = grant_q;
    assign end_transaction_out = end_out_q;
    assign error_out           = error_q;
    assign bus_busy            = busy_q;
    assign active_master       = active_q;

endmodule
